clock24_alarm: RTL

Parametrised successor of the 24-hour button-set clock. Generates its own 1 Hz tick and blink mask from a cycle divider, so there are no simulation-only enable or mask inputs; benches shrink TICK_DIV instead. Adds decrement editing, 12/24-hour display, and a settable alarm with timed ring. Drives four active-low 7-seg digits and binary LEDs on the board top.

---
 rtl/clock24_pkg.sv | 44 ++++
 rtl/seg7_dec.sv | 15 +
 rtl/clock24_alarm.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/clock24_pkg.sv
// Shared types, segment constants and small conversion helpers for the
// 24-hour alarm clock.
package clock24_pkg;

  typedef enum logic [2:0] {
    RUN,
    SET_SEC,
    SET_MIN,
    SET_HOUR,
    SET_AMIN,
    SET_AHOUR
  } mode_t;

  typedef enum logic {
    DISP_HM,
    DISP_MS
  } disp_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // gfedcba, active-low
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  function automatic logic [7:0] bin2bcd(input logic [5:0] v);
    return {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

  function automatic logic [4:0] hour12(input logic [4:0] h);
    if (h == 5'd0) return 5'd12;
    if (h > 5'd12) return h - 5'd12;
    return h;
  endfunction

  function automatic logic [5:0] wrap_step(input logic [5:0] v,
                                           input logic [5:0] max_v,
                                           input logic       up);
    if (up) return (v == max_v) ? 6'd0 : v + 6'd1;
    return (v == 6'd0) ? max_v : v - 6'd1;
  endfunction

endpackage

// File: rtl/seg7_dec.sv
// BCD digit to active-low 7-segment pattern with blanking.
module seg7_dec
  import clock24_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && bcd <= 4'd9) seg = SEG_DIGIT[bcd];
  end

endmodule

// File: rtl/clock24_alarm.sv
// 24-hour button-set clock with internal 1 Hz divider, 12/24h display,
// up/down field editing and a timed alarm.
module clock24_alarm
  import clock24_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 100000000,
  parameter int unsigned ALARM_SEC = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnr,
  input  logic       btnl,
  input  logic       btnu,
  input  logic       btnd,
  input  logic       sw_12h,
  input  logic       sw_alarm_en,
  output logic [6:0] disp3,
  output logic [6:0] disp2,
  output logic [6:0] disp1,
  output logic [6:0] disp0,
  output logic [4:0] hour_led,
  output logic [5:0] sec_led,
  output logic       pm_led,
  output logic       alarm_out
);

  localparam int unsigned   CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(TICK_DIV / 2);
  localparam logic [5:0]    RING_LOAD = 6'(ALARM_SEC);

  mode_t         mode, mode_next;
  disp_t         disp_mode;
  logic [CW-1:0] cnt;
  logic          tick, mask;
  logic [5:0]    sec, min, amin, ring;
  logic [4:0]    hour, ahour;

  logic          silence, act_l, act_r, act_u, act_d, enter_run;
  logic          sec_wrap, min_wrap, alarm_hit;
  logic [5:0]    t_sec, t_min;
  logic [4:0]    t_hour;

  logic [5:0]    left_val, right_val;
  logic          left_hour, blank_left, blank_right;
  logic [7:0]    left_bcd, right_bcd;
  logic [6:0]    seg3, seg2, seg1, seg0;

  assign tick = (cnt == CNT_MAX);
  assign mask = (cnt >= CNT_HALF);

  // While ringing, any button only silences; otherwise one action by priority.
  always_comb begin
    silence = alarm_out && (btnl || btnr || btnu || btnd);
    act_l   = !silence && btnl;
    act_r   = !silence && !btnl && btnr;
    act_u   = !silence && !btnl && !btnr && btnu;
    act_d   = !silence && !btnl && !btnr && !btnu && btnd;
  end

  always_comb begin
    mode_next = mode;
    case (mode)
      RUN:       if (act_l) mode_next = SET_SEC;
      SET_SEC:   if (act_l) mode_next = RUN; else if (act_r) mode_next = SET_MIN;
      SET_MIN:   if (act_l) mode_next = RUN; else if (act_r) mode_next = SET_HOUR;
      SET_HOUR:  if (act_l) mode_next = RUN; else if (act_r) mode_next = SET_AMIN;
      SET_AMIN:  if (act_l) mode_next = RUN; else if (act_r) mode_next = SET_AHOUR;
      SET_AHOUR: if (act_l) mode_next = RUN; else if (act_r) mode_next = SET_SEC;
      default:   mode_next = RUN;
    endcase
    enter_run = (mode != RUN) && (mode_next == RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mode <= RUN;
    else      mode <= mode_next;
  end

  always_comb begin
    sec_wrap  = (sec == 6'd59);
    min_wrap  = (min == 6'd59);
    t_sec     = sec_wrap ? 6'd0 : sec + 6'd1;
    t_min     = sec_wrap ? (min_wrap ? 6'd0 : min + 6'd1) : min;
    t_hour    = (sec_wrap && min_wrap) ? ((hour == 5'd23) ? 5'd0 : hour + 5'd1) : hour;
    alarm_hit = sw_alarm_en && (mode == RUN) && tick && sec_wrap &&
                (t_hour == ahour) && (t_min == amin);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      disp_mode <= DISP_HM;
      sec       <= '0;
      min       <= '0;
      hour      <= '0;
      amin      <= '0;
      ahour     <= '0;
      ring      <= '0;
      alarm_out <= 1'b0;
    end else begin
      cnt <= (enter_run || tick) ? '0 : cnt + CW'(1);

      if (mode == RUN) begin
        if (act_r) disp_mode <= (disp_mode == DISP_HM) ? DISP_MS : DISP_HM;
        if (tick) begin
          sec  <= t_sec;
          min  <= t_min;
          hour <= t_hour;
        end
      end else if (act_u || act_d) begin
        case (mode)
          SET_SEC:   sec   <= '0;
          SET_MIN:   min   <= wrap_step(min, 6'd59, act_u);
          SET_HOUR:  hour  <= 5'(wrap_step({1'b0, hour}, 6'd23, act_u));
          SET_AMIN:  amin  <= wrap_step(amin, 6'd59, act_u);
          SET_AHOUR: ahour <= 5'(wrap_step({1'b0, ahour}, 6'd23, act_u));
          default: ;
        endcase
      end

      if (!sw_alarm_en || silence) begin
        alarm_out <= 1'b0;
        ring      <= '0;
      end
      if (alarm_hit) begin
        alarm_out <= 1'b1;
        ring      <= RING_LOAD;
      end else if (sw_alarm_en && !silence && alarm_out && tick) begin
        ring <= ring - 6'd1;
        if (ring == 6'd1) alarm_out <= 1'b0;
      end
    end
  end

  always_comb begin
    left_val    = {1'b0, hour};
    right_val   = min;
    left_hour   = 1'b1;
    blank_left  = 1'b0;
    blank_right = 1'b0;
    case (mode)
      RUN: if (disp_mode == DISP_MS) begin
        left_val  = min;
        right_val = sec;
        left_hour = 1'b0;
      end
      SET_SEC: begin
        left_val    = min;
        right_val   = sec;
        left_hour   = 1'b0;
        blank_right = mask;
      end
      SET_MIN:  blank_right = mask;
      SET_HOUR: blank_left  = mask;
      SET_AMIN: begin
        left_val    = {1'b0, ahour};
        right_val   = amin;
        blank_right = mask;
      end
      SET_AHOUR: begin
        left_val   = {1'b0, ahour};
        right_val  = amin;
        blank_left = mask;
      end
      default: ;
    endcase
    if (left_hour && sw_12h) left_val = {1'b0, hour12(left_val[4:0])};
    left_bcd  = bin2bcd(left_val);
    right_bcd = bin2bcd(right_val);
  end

  seg7_dec u_dec3 (.bcd(left_bcd[7:4]),  .blank(blank_left),  .seg(seg3));
  seg7_dec u_dec2 (.bcd(left_bcd[3:0]),  .blank(blank_left),  .seg(seg2));
  seg7_dec u_dec1 (.bcd(right_bcd[7:4]), .blank(blank_right), .seg(seg1));
  seg7_dec u_dec0 (.bcd(right_bcd[3:0]), .blank(blank_right), .seg(seg0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp3    <= SEG_DIGIT[0];
      disp2    <= SEG_DIGIT[0];
      disp1    <= SEG_DIGIT[0];
      disp0    <= SEG_DIGIT[0];
      hour_led <= '0;
      sec_led  <= '0;
      pm_led   <= 1'b0;
    end else begin
      disp3    <= seg3;
      disp2    <= seg2;
      disp1    <= seg1;
      disp0    <= seg0;
      hour_led <= hour;
      sec_led  <= sec;
      pm_led   <= sw_12h && (hour >= 5'd12);
    end
  end

endmodule
